// File: rtl/wb4_to_pi1_pkg.sv
// Shared definitions for the WB4 -> PI1 bridge: PI1 op encodings, FSM states
// and a constant-evaluable clog2 used to size ports and FIFO pointers.
package wb4_to_pi1_pkg;

  localparam logic [1:0] PINOOP = 2'd0;
  localparam logic [1:0] PIWROP = 2'd1;
  localparam logic [1:0] PIRDOP = 2'd2;
  localparam logic [1:0] PIRWOP = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RDWAIT = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb4_to_pi1_fifo.sv
// In-order request FIFO: push/pop in the same cycle keeps the count, flush empties it.
// Zero-latency head (rdata_o is the oldest entry); a push while full is dropped.
module wb4_to_pi1_fifo
  import wb4_to_pi1_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [clog2(DEPTH):0] count_o
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/wb4_to_pi1.sv
// WB4 pipelined slave to PI1 master bridge; write ack 1 cycle after PI1 accept, read ack 1 cycle after data.
// Stalls when the request FIFO is full, cyc is low, or an aborted op is still retiring.
module wb4_to_pi1
  import wb4_to_pi1_pkg::*;
#(
  parameter int ARCHBITSZ = 32,
  parameter int FIFODEPTH = 4
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          wb4_cyc_i,
  input  logic                                          wb4_stb_i,
  input  logic                                          wb4_we_i,
  input  logic [ARCHBITSZ-1:0]                          wb4_addr_i,
  input  logic [ARCHBITSZ-1:0]                          wb4_data_i,
  input  logic [ARCHBITSZ/8-1:0]                        wb4_sel_i,
  output logic                                          wb4_stall_o,
  output logic                                          wb4_ack_o,
  output logic [ARCHBITSZ-1:0]                          wb4_data_o,
  output logic [1:0]                                    pi1_op_o,
  output logic [ARCHBITSZ-clog2(ARCHBITSZ/8)-1:0]       pi1_addr_o,
  output logic [ARCHBITSZ-1:0]                          pi1_data_o,
  input  logic [ARCHBITSZ-1:0]                          pi1_data_i,
  output logic [ARCHBITSZ/8-1:0]                        pi1_sel_o,
  input  logic                                          pi1_rdy_i
);

  localparam int SELSZ = ARCHBITSZ / 8;
  localparam int OFFW  = clog2(SELSZ);
  localparam int ADDRW = ARCHBITSZ - OFFW;
  localparam int ENTW  = 1 + ADDRW + ARCHBITSZ + SELSZ;
  localparam int CW    = clog2(FIFODEPTH) + 1;

  state_e                 state_q, state_d;
  logic                   ack_q, ack_d;
  logic                   abort_q, abort_d;
  logic                   live_q;
  logic [ARCHBITSZ-1:0]   rdata_q, rdata_d;

  logic [ENTW-1:0]        push_dat, head;
  logic                   fifo_full, fifo_empty, push, pi_acc, issue_active;
  logic [CW-1:0]          fifo_count;
  logic                   head_we;
  logic                   unused_addr;

  assign unused_addr = ^wb4_addr_i[OFFW-1:0];
  assign push_dat    = {wb4_we_i, wb4_addr_i[ARCHBITSZ-1:OFFW], wb4_data_i, wb4_sel_i};

  // live_q holds stall high from async reset assertion until the first clock after release.
  assign wb4_stall_o = ~live_q | fifo_full | ~wb4_cyc_i | abort_q;
  assign push        = wb4_cyc_i & wb4_stb_i & ~wb4_stall_o;

  wb4_to_pi1_fifo #(.WIDTH(ENTW), .DEPTH(FIFODEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pi_acc),
    .flush_i (~wb4_cyc_i),
    .wdata_i (push_dat),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // The head is driven straight from the FIFO so IDLE issues without a bubble.
  assign head_we      = head[ENTW-1];
  assign issue_active = (state_q != ST_RDWAIT) & ~fifo_empty;
  assign pi_acc       = issue_active & pi1_rdy_i;
  assign pi1_op_o     = issue_active ? (head_we ? PIWROP : PIRDOP) : PINOOP;
  assign pi1_addr_o   = issue_active ? head[ENTW-2 -: ADDRW] : '0;
  assign pi1_data_o   = issue_active ? head[SELSZ +: ARCHBITSZ] : '0;
  assign pi1_sel_o    = issue_active ? head[SELSZ-1:0] : '0;

  assign wb4_ack_o    = ack_q & wb4_cyc_i;
  assign wb4_data_o   = rdata_q;

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    abort_d = abort_q;
    case (state_q)
      ST_IDLE, ST_ISSUE: begin
        if (!issue_active) begin
          state_d = ST_IDLE;
        end else if (!pi1_rdy_i) begin
          state_d = ST_ISSUE;
        end else if (head_we) begin
          ack_d   = wb4_cyc_i & ~abort_q;
          state_d = (fifo_count > CW'(1)) ? ST_ISSUE : ST_IDLE;
        end else begin
          state_d = ST_RDWAIT;
        end
      end
      ST_RDWAIT: begin
        if (pi1_rdy_i) begin
          rdata_d = pi1_data_i;
          ack_d   = wb4_cyc_i & ~abort_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // An op already handed to PI1 when cyc drops must retire silently before new requests.
    if (!wb4_cyc_i && (pi_acc || state_q == ST_RDWAIT)) abort_d = 1'b1;
    else if (state_q != ST_RDWAIT)                        abort_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      abort_q <= 1'b0;
      live_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      abort_q <= abort_d;
      live_q  <= 1'b1;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_wb4_to_pi1.sv
// Directed bench for wb4_to_pi1: per-cycle vector table plus burst, mixed, abort and reset sequences.
module tb_wb4_to_pi1;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        wb4_cyc_i = 1'b0, wb4_stb_i = 1'b0, wb4_we_i = 1'b0;
  logic [31:0] wb4_addr_i = '0, wb4_data_i = '0;
  logic [3:0]  wb4_sel_i = '0;
  logic        wb4_stall_o, wb4_ack_o;
  logic [31:0] wb4_data_o;
  logic [1:0]  pi1_op_o;
  logic [29:0] pi1_addr_o;
  logic [31:0] pi1_data_o;
  logic [31:0] pi1_data_i = '0;
  logic [3:0]  pi1_sel_o;
  logic        pi1_rdy_i = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [1:0]  mon_op   [$];
  logic [29:0] mon_addr [$];
  logic [31:0] mon_wdat [$];
  logic [31:0] mon_ack  [$];

  always #5 clk_i = ~clk_i;

  wb4_to_pi1 #(.ARCHBITSZ(32), .FIFODEPTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wb4_cyc_i(wb4_cyc_i), .wb4_stb_i(wb4_stb_i), .wb4_we_i(wb4_we_i),
    .wb4_addr_i(wb4_addr_i), .wb4_data_i(wb4_data_i), .wb4_sel_i(wb4_sel_i),
    .wb4_stall_o(wb4_stall_o), .wb4_ack_o(wb4_ack_o), .wb4_data_o(wb4_data_o),
    .pi1_op_o(pi1_op_o), .pi1_addr_o(pi1_addr_o), .pi1_data_o(pi1_data_o),
    .pi1_data_i(pi1_data_i), .pi1_sel_o(pi1_sel_o), .pi1_rdy_i(pi1_rdy_i)
  );

  // Passive log of accepted PI1 ops and delivered acks, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (pi1_op_o != 2'd0 && pi1_rdy_i) begin
        mon_op.push_back(pi1_op_o);
        mon_addr.push_back(pi1_addr_o);
        mon_wdat.push_back(pi1_data_o);
      end
      if (wb4_ack_o) mon_ack.push_back(wb4_data_o);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_mon();
    mon_op.delete();
    mon_addr.delete();
    mon_wdat.delete();
    mon_ack.delete();
  endtask

  task automatic drive(input logic cyc, input logic stb, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] sel, input logic rdy);
    wb4_cyc_i = cyc; wb4_stb_i = stb; wb4_we_i = we;
    wb4_addr_i = addr; wb4_data_i = data; wb4_sel_i = sel; pi1_rdy_i = rdy;
  endtask

  typedef struct {
    logic        cyc, stb, we;
    logic [31:0] addr, data;
    logic [3:0]  sel;
    logic        rdy;
    logic [31:0] pdin;
    logic        e_stall, e_ack;
    logic [1:0]  e_op;
    logic [29:0] e_paddr;
    logic [31:0] e_pdata;
    logic [3:0]  e_psel;
    logic        e_chk;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl [12];

  logic        mx_we   [8];
  logic [31:0] mx_addr [8];
  logic [31:0] mx_data [8];
  logic [3:0]  mx_sel  [8];
  logic [31:0] mx_exp  [8];
  logic [31:0] smem    [4];

  initial begin
    int sent, rd_idx, ncyc;
    logic [29:0] wa;

    // Single write: ack two cycles after the strobe cycle. Single read: rdy held off 3 cycles.
    tbl[0]  = '{1'b1,1'b1,1'b1,32'h100,32'hDEADBEEF,4'hF,1'b1,32'h0, 1'b0,1'b0,2'd0,30'h0, 32'h0,       4'h0,1'b0,32'h0};
    tbl[1]  = '{1'b1,1'b0,1'b0,32'h0,  32'h0,       4'h0,1'b1,32'h0, 1'b0,1'b0,2'd1,30'h40,32'hDEADBEEF,4'hF,1'b0,32'h0};
    tbl[2]  = '{1'b1,1'b0,1'b0,32'h0,  32'h0,       4'h0,1'b1,32'h0, 1'b0,1'b1,2'd0,30'h0, 32'h0,       4'h0,1'b0,32'h0};
    tbl[3]  = '{1'b1,1'b0,1'b0,32'h0,  32'h0,       4'h0,1'b1,32'h0, 1'b0,1'b0,2'd0,30'h0, 32'h0,       4'h0,1'b0,32'h0};
    tbl[4]  = '{1'b1,1'b1,1'b0,32'h200,32'h0,       4'hF,1'b0,32'h0, 1'b0,1'b0,2'd0,30'h0, 32'h0,       4'h0,1'b0,32'h0};
    tbl[5]  = '{1'b1,1'b0,1'b0,32'h0,  32'h0,       4'h0,1'b0,32'h0, 1'b0,1'b0,2'd2,30'h80,32'h0,       4'hF,1'b0,32'h0};
    tbl[6]  = '{1'b1,1'b0,1'b0,32'h0,  32'h0,       4'h0,1'b0,32'h0, 1'b0,1'b0,2'd2,30'h80,32'h0,       4'hF,1'b0,32'h0};
    tbl[7]  = '{1'b1,1'b0,1'b0,32'h0,  32'h0,       4'h0,1'b0,32'h0, 1'b0,1'b0,2'd2,30'h80,32'h0,       4'hF,1'b0,32'h0};
    tbl[8]  = '{1'b1,1'b0,1'b0,32'h0,  32'h0,       4'h0,1'b1,32'h0, 1'b0,1'b0,2'd2,30'h80,32'h0,       4'hF,1'b0,32'h0};
    tbl[9]  = '{1'b1,1'b0,1'b0,32'h0,  32'h0,       4'h0,1'b1,32'h12345678, 1'b0,1'b0,2'd0,30'h0,32'h0, 4'h0,1'b0,32'h0};
    tbl[10] = '{1'b1,1'b0,1'b0,32'h0,  32'h0,       4'h0,1'b0,32'h0, 1'b0,1'b1,2'd0,30'h0, 32'h0,       4'h0,1'b1,32'h12345678};
    tbl[11] = '{1'b1,1'b0,1'b0,32'h0,  32'h0,       4'h0,1'b0,32'h0, 1'b0,1'b0,2'd0,30'h0, 32'h0,       4'h0,1'b1,32'h12345678};

    // Mixed traffic over 4 words; slave memory starts with a per-word pattern.
    mx_we   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    mx_addr = '{32'h300, 32'h300, 32'h304, 32'h304, 32'h308, 32'h30C, 32'h30C, 32'h300};
    mx_data = '{32'h11112222, 32'h0, 32'h33334444, 32'h0, 32'h0, 32'h55556666, 32'h0, 32'h0};
    mx_sel  = '{4'hF, 4'hF, 4'h3, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    mx_exp  = '{32'h0, 32'h11112222, 32'h0, 32'hB0B04444, 32'hC0C0C0C0, 32'h0, 32'h55556666, 32'h11112222};
    smem    = '{32'hA0A0A0A0, 32'hB0B0B0B0, 32'hC0C0C0C0, 32'hD0D0D0D0};

    // Reset state
    #12;
    chk("rst_stall", 64'(wb4_stall_o), 64'd1);
    chk("rst_ack",   64'(wb4_ack_o),   64'd0);
    chk("rst_op",    64'(pi1_op_o),    64'd0);
    chk("rst_rdata", 64'(wb4_data_o),  64'd0);
    chk("rst_paddr", 64'(pi1_addr_o),  64'd0);
    #11 rst_ni = 1'b1;
    tick();
    tick();
    clear_mon();

    for (int i = 0; i < 12; i++) begin
      tick();
      drive(tbl[i].cyc, tbl[i].stb, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].sel, tbl[i].rdy);
      pi1_data_i = tbl[i].pdin;
      @(negedge clk_i);
      chk($sformatf("vec%0d_stall", i), 64'(wb4_stall_o), 64'(tbl[i].e_stall));
      chk($sformatf("vec%0d_ack", i),   64'(wb4_ack_o),   64'(tbl[i].e_ack));
      chk($sformatf("vec%0d_op", i),    64'(pi1_op_o),    64'(tbl[i].e_op));
      if (tbl[i].e_op != 2'd0) begin
        chk($sformatf("vec%0d_paddr", i), 64'(pi1_addr_o), 64'(tbl[i].e_paddr));
        chk($sformatf("vec%0d_psel", i),  64'(pi1_sel_o),  64'(tbl[i].e_psel));
      end
      if (tbl[i].e_op == 2'd1) chk($sformatf("vec%0d_pdata", i), 64'(pi1_data_o), 64'(tbl[i].e_pdata));
      if (tbl[i].e_chk)        chk($sformatf("vec%0d_rdata", i), 64'(wb4_data_o), 64'(tbl[i].e_rdata));
    end
    chk("single_op_count",  64'(mon_op.size()),  64'd2);
    chk("single_ack_count", 64'(mon_ack.size()), 64'd2);

    // Burst of 6 writes against a 4-deep FIFO, PI1 not ready for the first 10 cycles
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    clear_mon();
    sent = 0;
    ncyc = 0;
    while (sent < 6 && ncyc < 60) begin
      tick();
      drive(1'b1, 1'b1, 1'b1, 32'h1000 + 32'(sent) * 4, 32'hA0000000 + 32'(sent), 4'hF, ncyc >= 10);
      @(negedge clk_i);
      if (ncyc < 4)                chk($sformatf("burst_accept%0d", ncyc), 64'(wb4_stall_o), 64'd0);
      if (ncyc >= 4 && ncyc < 10)  chk($sformatf("burst_full%0d", ncyc),   64'(wb4_stall_o), 64'd1);
      if (!wb4_stall_o) sent++;
      ncyc++;
    end
    for (int n = 0; n < 40 && mon_ack.size() < 6; n++) begin
      tick();
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
      @(negedge clk_i);
    end
    chk("burst_op_count",  64'(mon_op.size()),  64'd6);
    chk("burst_ack_count", 64'(mon_ack.size()), 64'd6);
    for (int k = 0; k < 6 && k < mon_op.size(); k++) begin
      chk($sformatf("burst_op%0d", k),    64'(mon_op[k]),   64'd1);
      chk($sformatf("burst_addr%0d", k),  64'(mon_addr[k]), 64'(30'h400 + 30'(k)));
      chk($sformatf("burst_wdata%0d", k), 64'(mon_wdat[k]), 64'(32'hA0000000 + 32'(k)));
    end

    // Mixed writes/reads with random PI1 ready and a byte-lane-aware slave
    tick();
    clear_mon();
    sent = 0;
    rd_idx = 0;
    for (int n = 0; n < 300 && mon_ack.size() < 8; n++) begin
      tick();
      if (sent < 8) drive(1'b1, 1'b1, mx_we[sent], mx_addr[sent], mx_data[sent], mx_sel[sent], 1'($urandom_range(0, 1)));
      else          drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'($urandom_range(0, 1)));
      pi1_data_i = smem[rd_idx];
      @(negedge clk_i);
      if (sent < 8 && !wb4_stall_o) sent++;
      if (pi1_rdy_i && pi1_op_o == 2'd1) begin
        for (int b = 0; b < 4; b++)
          if (pi1_sel_o[b]) smem[pi1_addr_o[1:0]][b*8 +: 8] = pi1_data_o[b*8 +: 8];
      end
      if (pi1_rdy_i && pi1_op_o == 2'd2) rd_idx = int'(pi1_addr_o[1:0]);
    end
    chk("mixed_ack_count", 64'(mon_ack.size()), 64'd8);
    chk("mixed_op_count",  64'(mon_op.size()),  64'd8);
    for (int k = 0; k < 8 && k < mon_op.size(); k++) begin
      chk($sformatf("mixed_op%0d", k),   64'(mon_op[k]),   mx_we[k] ? 64'd1 : 64'd2);
      chk($sformatf("mixed_addr%0d", k), 64'(mon_addr[k]), 64'(mx_addr[k] >> 2));
    end
    for (int k = 0; k < 8 && k < mon_ack.size(); k++)
      if (!mx_we[k]) chk($sformatf("mixed_rdata%0d", k), 64'(mon_ack[k]), 64'(mx_exp[k]));

    // Abort: read in RDWAIT, three writes queued, then cyc drops
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    clear_mon();
    tick(); drive(1'b1, 1'b1, 1'b0, 32'h700, 32'h0, 4'hF, 1'b0); @(negedge clk_i);
    chk("abort_push_rd", 64'(wb4_stall_o), 64'd0);
    tick(); drive(1'b1, 1'b1, 1'b1, 32'h704, 32'h1, 4'hF, 1'b1); @(negedge clk_i);
    chk("abort_rd_issue", 64'(pi1_op_o), 64'd2);
    tick(); drive(1'b1, 1'b1, 1'b1, 32'h708, 32'h2, 4'hF, 1'b0); @(negedge clk_i);
    tick(); drive(1'b1, 1'b1, 1'b1, 32'h70C, 32'h3, 4'hF, 1'b0); @(negedge clk_i);
    chk("abort_rdwait_noop", 64'(pi1_op_o), 64'd0);
    for (int n = 0; n < 5; n++) begin
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, n >= 2);
      pi1_data_i = 32'hCAFE0000;
      @(negedge clk_i);
      chk($sformatf("abort_stall%0d", n), 64'(wb4_stall_o), 64'd1);
      chk($sformatf("abort_ack%0d", n),   64'(wb4_ack_o),   64'd0);
    end
    for (int n = 0; n < 3; n++) begin
      tick();
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
      @(negedge clk_i);
      chk($sformatf("abort_flushed%0d", n), 64'(pi1_op_o), 64'd0);
    end
    chk("abort_op_count",  64'(mon_op.size()),  64'd1);
    chk("abort_ack_count", 64'(mon_ack.size()), 64'd0);
    sent = 0;
    for (int n = 0; n < 20 && mon_ack.size() < 1; n++) begin
      tick();
      drive(1'b1, sent == 0, 1'b1, 32'h800, 32'h99, 4'hF, 1'b1);
      @(negedge clk_i);
      if (!wb4_stall_o && wb4_stb_i) sent = 1;
    end
    chk("abort_recover_ack", 64'(mon_ack.size()), 64'd1);
    chk("abort_recover_ops", 64'(mon_op.size()),  64'd2);

    // Async reset asserted between edges while a write sits in ISSUE
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    clear_mon();
    tick(); drive(1'b1, 1'b1, 1'b1, 32'h500, 32'h77, 4'hF, 1'b0); @(negedge clk_i);
    tick(); drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    tick();
    #2;
    chk("rstmid_pre_op", 64'(pi1_op_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("rstmid_op",    64'(pi1_op_o),    64'd0);
    chk("rstmid_stall", 64'(wb4_stall_o), 64'd1);
    chk("rstmid_ack",   64'(wb4_ack_o),   64'd0);
    @(negedge clk_i);
    #2 rst_ni = 1'b1;
    sent = 0;
    wa = 30'h180;
    for (int n = 0; n < 20 && mon_ack.size() < 1; n++) begin
      tick();
      drive(1'b1, sent == 0, 1'b1, 32'h600, 32'h88, 4'hF, 1'b1);
      @(negedge clk_i);
      if (!wb4_stall_o && wb4_stb_i) sent = 1;
    end
    chk("rstmid_ack_count", 64'(mon_ack.size()), 64'd1);
    chk("rstmid_op_count",  64'(mon_op.size()),  64'd1);
    if (mon_op.size() > 0) chk("rstmid_op_addr", 64'(mon_addr[0]), 64'(wa));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
